// File: rtl/x86_ucode_sequencer.sv
// Microsequencer stepping through the fixed microstate sequence of each accepted instruction
// class, with a memory handshake, a wait timeout, fault reporting and a retired-instruction count.
module x86_ucode_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inst_valid,
    input  logic [7:0]       opcode,
    input  logic [7:0]       modrm,
    output logic             inst_ready,
    output logic [7:0]       opcode_q,
    output logic [7:0]       modrm_q,
    output logic [7:0]       state,
    output logic             mem_req,
    output logic             mem_we,
    input  logic             mem_ready,
    output logic             done,
    output logic             fault,
    output logic [CNT_W-1:0] retired
);

    localparam int unsigned WaitW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

    // Encodings are shared with the datapath control decoder and must not change.
    typedef enum logic [7:0] {
        StIdle   = 8'd0,
        StAgen   = 8'd1,
        StMemRd  = 8'd2,
        StAluMdr = 8'd3,
        StRegAlu = 8'd4,
        StMdrAlu = 8'd5,
        StMemWr  = 8'd6,
        StAluRr  = 8'd8,
        StMovImm = 8'd12,
        StJmp    = 8'd16
    } state_e;

    typedef enum logic [2:0] {
        ClsIllegal,
        ClsMov,
        ClsRegReg,
        ClsLoadOp,
        ClsRmw,
        ClsJmp
    } cls_e;

    function automatic cls_e classify(input logic [7:0] op, input logic [1:0] md);
        logic alu_load;
        logic alu_rmw;
        alu_load = (op == 8'h03) || (op == 8'h0B);
        alu_rmw  = (op == 8'h01) || (op == 8'h09) || (op == 8'h81) || (op == 8'h83) ||
                   (op == 8'hC1) || (op == 8'hD1) || (op == 8'hD3);
        if (op[7:4] == 4'hB) begin
            return ClsMov;
        end else if ((alu_load || alu_rmw) && (md == 2'b11)) begin
            return ClsRegReg;
        end else if (alu_load) begin
            return ClsLoadOp;
        end else if (alu_rmw) begin
            return ClsRmw;
        end else if ((op == 8'hE9) || (op == 8'hEB)) begin
            return ClsJmp;
        end
        return ClsIllegal;
    endfunction

    state_e             state_q, state_d;
    logic [WaitW-1:0]   wait_q, wait_d;
    logic               fault_q, fault_d;
    logic [CNT_W-1:0]   retired_q;
    logic [7:0]         opcode_r, modrm_r;
    logic               accept;
    logic               retire;
    logic               wait_last;

    assign accept    = inst_valid && (state_q == StIdle);
    assign wait_last = (wait_q == WaitW'(MEM_TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        fault_d = 1'b0;
        retire  = 1'b0;
        case (state_q)
            StIdle: begin
                if (inst_valid) begin
                    case (classify(opcode, modrm[7:6]))
                        ClsMov:              state_d = StMovImm;
                        ClsRegReg:           state_d = StAluRr;
                        ClsLoadOp, ClsRmw:   state_d = StAgen;
                        ClsJmp:              state_d = StJmp;
                        default:             fault_d = 1'b1;
                    endcase
                end
            end
            StAgen: begin
                state_d = StMemRd;
                wait_d  = '0;
            end
            StMemRd, StMemWr: begin
                // A ready in the last allowed cycle takes priority over the timeout.
                if (mem_ready) begin
                    wait_d  = '0;
                    if (state_q == StMemRd) begin
                        state_d = StAluMdr;
                    end else begin
                        state_d = StIdle;
                        retire  = 1'b1;
                    end
                end else if (wait_last) begin
                    state_d = StIdle;
                    wait_d  = '0;
                    fault_d = 1'b1;
                end else begin
                    wait_d = wait_q + WaitW'(1);
                end
            end
            StAluMdr: begin
                state_d = (classify(opcode_r, modrm_r[7:6]) == ClsLoadOp) ? StRegAlu : StMdrAlu;
            end
            StMdrAlu: begin
                state_d = StMemWr;
                wait_d  = '0;
            end
            StRegAlu, StAluRr, StMovImm, StJmp: begin
                state_d = StIdle;
                retire  = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            wait_q    <= '0;
            fault_q   <= 1'b0;
            retired_q <= '0;
            opcode_r  <= '0;
            modrm_r   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            fault_q <= fault_d;
            if (retire) begin
                retired_q <= retired_q + CNT_W'(1);
            end
            if (accept) begin
                opcode_r <= opcode;
                modrm_r  <= modrm;
            end
        end
    end

    assign state      = state_q;
    assign inst_ready = (state_q == StIdle);
    assign mem_req    = (state_q == StMemRd) || (state_q == StMemWr);
    assign mem_we     = (state_q == StMemWr);
    assign done       = retire;
    assign fault      = fault_q;
    assign retired    = retired_q;
    assign opcode_q   = opcode_r;
    assign modrm_q    = modrm_r;

endmodule

// File: doc/x86_ucode_sequencer.md
# x86_ucode_sequencer

Microsequencer that drives the `state` input of the datapath control decoder. It accepts one decoded instruction (opcode, ModRM) at a time and steps through the microstate sequence for that instruction class: MOV-imm, reg-reg ALU, load-op, read-modify-write or relative jump. During memory microstates it handshakes with the memory interface, and it reports completion, faults and a retired-instruction count. It sits between the fetch/decode stage and the datapath control decoder, and its `state` and latched `opcode_q`/`modrm_q` feed that decoder directly.

## Interface
Parameters:
- MEM_TIMEOUT, 16: maximum cycles a memory microstate waits for `mem_ready` before faulting (≥2).
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- inst_valid  in  1  decode presents a valid instruction.
- opcode  in  8  primary opcode byte.
- modrm  in  8  ModRM byte; don't-care for B8–BF, E9, EB.
- inst_ready  out  1  sequencer can accept an instruction.
- opcode_q  out  8  latched opcode, held for the whole sequence.
- modrm_q  out  8  latched ModRM, held for the whole sequence.
- state  out  8  current microstate number, to the datapath control decoder.
- mem_req  out  1  memory access in progress.
- mem_we  out  1  the access is a write; valid only with `mem_req`.
- mem_ready  in  1  memory completes the current access this cycle.
- done  out  1  one-cycle pulse in the final microstate of an instruction.
- fault  out  1  one-cycle pulse on an illegal opcode or a memory timeout.
- retired  out  CNT_W  count of completed instructions.

## Operation
Microstate encodings, which are fixed and shared with the decoder:
- 0 IDLE
- 1 MAR←AGEN
- 2 MEM_RD wait
- 3 ALU_R←MDR
- 4 REG←ALU
- 5 MDR←ALU
- 6 MEM_WR wait
- 8 reg-reg ALU
- 12 MOV imm
- 16 JMP

Accept rule:
- An instruction is accepted when `inst_valid` and `inst_ready` are both high.
- `inst_ready` = (state == 0).
- On acceptance, `opcode` and `modrm` are latched into `opcode_q`/`modrm_q`; these hold until the next acceptance.

Sequence selection by `opcode_q` and mod = `modrm_q[7:6]`:
- B0–BF MOV imm: 12 → 0.
- 01, 09, 03, 0B, 81, 83, C1, D1, D3 with mod = 11: 8 → 0.
- 03, 0B with mod ≠ 11 (load-op): 1 → 2 → 3 → 4 → 0.
- 01, 09, 81, 83, C1, D1, D3 with mod ≠ 11 (read-modify-write): 1 → 2 → 3 → 5 → 6 → 0.
- E9, EB: 16 → 0.
- Any other opcode: no datapath microstates. `fault` pulses in the cycle after acceptance, state stays 0, `retired` is unchanged.

Memory wait states (2 and 6):
- `mem_req` = 1 in both; `mem_we` = 1 only in state 6.
- The sequencer holds the state while `mem_ready` = 0, then advances on the edge where `mem_ready` = 1.
- A wait counter clears on entry and increments each cycle in the wait state.
- If `mem_ready` is still 0 after MEM_TIMEOUT cycles in the state, `fault` pulses, the next state is 0, and there is no `done` and no retire.
- `mem_ready` outside states 2 and 6 is ignored.

Completion:
- `done` = 1 during the final microstate of a sequence (the microstate whose successor is 0).
- `retired` increments on that edge and wraps modulo 2^CNT_W.

Reset, asynchronous and also mid-sequence:
- state = 0, inst_ready = 1, mem_req = 0, mem_we = 0, done = 0, fault = 0.
- opcode_q = 0, modrm_q = 0, retired = 0, wait counter = 0.
- An aborted instruction neither retires nor faults.

## Timing
- Acceptance at edge N puts the first microstate on `state` in cycle N+1. Outputs are registered or decoded from registered state only.
- Latency to `done` (no memory stalls, w = mem wait cycles):
  - MOV, reg-reg, JMP: 1 cycle.
  - Load-op: 4 + w cycles.
  - RMW: 5 + w_rd + w_wr cycles.
- Back-to-back: after `done` the sequencer returns to state 0 for one cycle, so the minimum issue interval is 2 cycles.
- `mem_ready` asserted in the first cycle of state 2 gives a one-cycle residency in state 2.
- The timeout fault is raised in the MEM_TIMEOUT-th cycle of residency. A `mem_ready` arriving in that same cycle wins: the sequencer advances and no fault is raised.
- `inst_valid` while `inst_ready` = 0 is ignored and not queued.

## Test plan
- Reset, then accept B8: `state` = 12 for exactly one cycle with `done` = 1, then 0; `retired` = 1; `mem_req` stays 0.
- Accept 03/9D with `mem_ready` first high on the third cycle of state 2: `state` sequence is 1,2,2,2,3,4,0; `done` only in state 4; `mem_we` = 0 throughout.
- Accept 01/9D with `mem_ready` immediate in both waits: `state` sequence is 1,2,3,5,6,0; `mem_we` = 1 only in 6; `retired` +1.
- Accept 01/C8, then 83/C0, then E9 back-to-back: states 8,0,8,0,16,0; `retired` = 3; `opcode_q` tracks each accepted opcode.
- MEM_TIMEOUT = 4, accept 03/9D, hold `mem_ready` = 0: 4 cycles in state 2, `fault` pulse, state returns to 0, `retired` unchanged. Repeat with `mem_ready` in the 4th cycle: no fault, advances to 3.
- Accept opcode 0F: `fault` pulse, no `done`, state stays 0. Separately, drop `rst_n` while in state 2: state = 0 and all outputs at reset values immediately; `retired` = 0.
